// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp type, fault codes, monitor states and level-violation classifier
package traffic_pkg;
  typedef enum logic [1:0] {PASS, CONFIRM, FLASH, HOLD} state_t;
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;
  localparam logic [2:0] FLT_NONE = 3'd0;
  localparam logic [2:0] FLT_CONFLICT = 3'd1;
  localparam logic [2:0] FLT_MULTI = 3'd2;
  localparam logic [2:0] FLT_DARK = 3'd3;
  localparam logic [2:0] FLT_SHORT_Y = 3'd4;
  localparam lamp_t LAMP_RED = 3'b100;
  function automatic logic multi_lit(lamp_t l);
    return (l.red & l.yellow) | (l.red & l.green) | (l.yellow & l.green);
  endfunction
  function automatic logic [2:0] level_code(lamp_t ns, lamp_t ew);
    return ((ns.yellow | ns.green) & (ew.yellow | ew.green)) ? FLT_CONFLICT :
           (multi_lit(ns) | multi_lit(ew)) ? FLT_MULTI :
           (ns == '0 || ew == '0) ? FLT_DARK : FLT_NONE;
  endfunction
endpackage

// File: rtl/yellow_guard.sv
// yellow_guard: per-direction short-yellow detector; ports clk, rst, lamp (current command), freeze (skip history update on level-violating frames), short_y (green->red or yellow shorter than MIN_YELLOW)
module yellow_guard
  import traffic_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  lamp_t lamp,
  input  logic  freeze,
  output logic  short_y
);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  logic prev_g, prev_y;
  logic [YW-1:0] ycnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev_g <= 1'b0;
      prev_y <= 1'b0;
      ycnt <= '0;
    end else if (!freeze) begin
      prev_g <= lamp.green;
      prev_y <= lamp.yellow;
      ycnt <= !lamp.yellow ? '0 : (ycnt == YW'(MIN_YELLOW)) ? ycnt : ycnt + 1'b1;
    end
  assign short_y = lamp.red & (prev_g | (prev_y & (ycnt < YW'(MIN_YELLOW))));
endmodule

// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor: registered lamp pass-through with conflict/multi/dark/short-yellow checking; ports clk, rst, in_* lamp commands, fault_clr, registered lamp drives, fault, flash, fault_code
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int CONFIRM_CYCLES = 2,
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_HALF = 5,
  parameter int CLEAR_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_ns_red,
  input  logic       in_ns_yellow,
  input  logic       in_ns_green,
  input  logic       in_ew_red,
  input  logic       in_ew_yellow,
  input  logic       in_ew_green,
  input  logic       fault_clr,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       fault,
  output logic       flash,
  output logic [2:0] fault_code
);
  localparam int CW = $clog2(CONFIRM_CYCLES + 1);
  localparam int FW = $clog2(FLASH_HALF + 1);
  localparam int HW = $clog2(CLEAR_HOLD + 1);
  state_t state, state_n;
  lamp_t in_ns, in_ew, ns_q, ew_q, ns_n, ew_n;
  logic [CW-1:0] ccnt, ccnt_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic phase, phase_n;
  logic [2:0] code_n, lvl, trip_code;
  logic lvl_v, sy_ns, sy_ew, sy, confirm, trip, half_done, hold_done;
  assign in_ns = {in_ns_red, in_ns_yellow, in_ns_green};
  assign in_ew = {in_ew_red, in_ew_yellow, in_ew_green};
  assign lvl = level_code(in_ns, in_ew);
  assign lvl_v = lvl != FLT_NONE;
  yellow_guard #(.MIN_YELLOW(MIN_YELLOW)) u_ns (.clk(clk), .rst(rst), .lamp(in_ns), .freeze(lvl_v), .short_y(sy_ns));
  yellow_guard #(.MIN_YELLOW(MIN_YELLOW)) u_ew (.clk(clk), .rst(rst), .lamp(in_ew), .freeze(lvl_v), .short_y(sy_ew));
  assign sy = sy_ns | sy_ew;
  assign confirm = lvl_v && (int'(ccnt) + 1 >= CONFIRM_CYCLES);
  assign trip = (state == PASS || state == CONFIRM) ? (confirm || sy) : (state == HOLD) && (lvl_v || sy);
  assign trip_code = (confirm || (state == HOLD && lvl_v)) ? lvl : FLT_SHORT_Y;
  assign half_done = fcnt == FW'(FLASH_HALF - 1);
  assign hold_done = hcnt == HW'(CLEAR_HOLD - 1);
  always_comb begin
    state_n = state;
    ccnt_n = ccnt;
    fcnt_n = fcnt;
    hcnt_n = hcnt;
    phase_n = phase;
    code_n = fault_code;
    ns_n = in_ns;
    ew_n = in_ew;
    if (trip) begin
      state_n = FLASH;
      code_n = trip_code;
      ccnt_n = '0;
      fcnt_n = '0;
      hcnt_n = '0;
      phase_n = 1'b1;
      ns_n = LAMP_RED;
      ew_n = LAMP_RED;
    end else
      case (state)
        PASS, CONFIRM: begin
          state_n = lvl_v ? CONFIRM : PASS;
          ccnt_n = lvl_v ? ccnt + 1'b1 : '0;
        end
        FLASH: begin
          fcnt_n = half_done ? '0 : fcnt + 1'b1;
          phase_n = phase ^ half_done;
          state_n = (fault_clr && !lvl_v) ? HOLD : FLASH;
          hcnt_n = '0;
          ns_n = (phase_n || state_n == HOLD) ? LAMP_RED : '0;
          ew_n = ns_n;
        end
        default: begin
          state_n = hold_done ? PASS : HOLD;
          hcnt_n = hold_done ? '0 : hcnt + 1'b1;
          ns_n = hold_done ? in_ns : LAMP_RED;
          ew_n = hold_done ? in_ew : LAMP_RED;
        end
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PASS;
      ccnt <= '0;
      fcnt <= '0;
      hcnt <= '0;
      phase <= 1'b0;
      fault_code <= FLT_NONE;
      ns_q <= LAMP_RED;
      ew_q <= LAMP_RED;
    end else begin
      state <= state_n;
      ccnt <= ccnt_n;
      fcnt <= fcnt_n;
      hcnt <= hcnt_n;
      phase <= phase_n;
      fault_code <= code_n;
      ns_q <= ns_n;
      ew_q <= ew_n;
    end
  assign {ns_red, ns_yellow, ns_green} = ns_q;
  assign {ew_red, ew_yellow, ew_green} = ew_q;
  assign fault = state == FLASH;
  assign flash = fault;
endmodule
